l3_port_arbiter: RTL and testbench
==================================

Name: l3_port_arbiter

Overview:
- Round-robin request arbiter in front of the shared L3 cache lookup pipeline. Multiplexes up to NUM_PORTS L2-side requesters onto one downstream request channel.
- Tags each issued request with its source port. Routes tagged responses back to the owning port.
- Enforces a per-port outstanding limit.
- Quiesces traffic for coherency snoops via a snoop request/acknowledge handshake.

Parameters:
- NUM_PORTS, 8, number of L2 requesters (≥2).
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 512, cache-line data width.
- MAX_OUTSTANDING, 4, maximum in-flight requests per port (≥1).
- TAG_WIDTH, $clog2(NUM_PORTS), port tag width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port request accept
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- req_write  in  NUM_PORTS  1=write, 0=read
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed per-port write data
- cache_req_valid  out  1  downstream request valid
- cache_req_ready  in  1  downstream accept
- cache_req_addr  out  ADDR_WIDTH  issued address
- cache_req_write  out  1  issued type
- cache_req_wdata  out  DATA_WIDTH  issued write data
- cache_req_tag  out  TAG_WIDTH  source port of issued request
- cache_resp_valid  in  1  downstream response valid (no backpressure)
- cache_resp_tag  in  TAG_WIDTH  port the response belongs to
- cache_resp_data  in  DATA_WIDTH  read data (ignored for writes)
- resp_valid  out  NUM_PORTS  one-hot response strobe
- resp_data  out  DATA_WIDTH  response data, broadcast to all ports
- snoop_req  in  1  level request to quiesce
- snoop_ack  out  1  quiesced indication
- protocol_error  out  1  sticky: response for a port with zero outstanding
- grant_count  out  32  total requests issued (wraps)

Behaviour:
- Reset: clk and rst_n are the clock and asynchronous active-low reset.
  - State ARB; rr pointer 0; all outstanding counters 0.
  - cache_req_valid, cache_req_addr/write/wdata/tag, protocol_error and grant_count all 0.
  - Reset mid-operation discards all in-flight tracking. Responses arriving after reset with zero count set protocol_error.
- Eligible port p: req_valid[p] && cnt[p] < MAX_OUTSTANDING && !snoop_req.
- State ARB:
  - If any port is eligible, grant the first eligible port searching upward from rr pointer with wrap (rr, rr+1, …, NUM_PORTS-1, 0, …).
  - req_ready[p] is combinational and one-hot to the granted port, asserted only in ARB. All other req_ready bits are 0.
  - On grant: register that port's addr/write/wdata into the cache_req_* registers, tag←p, cache_req_valid←1, cnt[p]++, grant_count++, rr←(p+1) mod NUM_PORTS, next state ISSUE.
  - If no port is eligible, remain in ARB.
- State ISSUE:
  - cache_req_* held stable while cache_req_valid && !cache_req_ready.
  - On cache_req_ready: cache_req_valid←0, next state ARB.
  - Minimum issue interval is 2 cycles.
- Responses (combinational, any state):
  - resp_valid = cache_resp_valid ? (1<<cache_resp_tag) : 0.
  - resp_data = cache_resp_data.
  - cnt[tag]-- at the clock edge.
  - Grant and response on the same port in the same cycle: cnt unchanged.
  - Response with cnt[tag]==0 or tag ≥ NUM_PORTS: cnt unchanged, protocol_error←1 (sticky until reset). resp_valid is still driven for valid tags.
- Snoop:
  - While snoop_req=1, no new grants occur. A request already in ISSUE completes normally.
  - snoop_ack = snoop_req && state==ARB && sum(cnt)==0. Combinational from registered state and counters.
  - Deasserting snoop_req resumes arbitration next cycle; rr pointer is preserved.
- Counter width is $clog2(MAX_OUTSTANDING+1). Counters never exceed MAX_OUTSTANDING and never underflow.

Test Plan:
1. Reset, port 2 requests read addr 0x10000, cache_req_ready=1 → req_ready[2] high one cycle; next cycle cache_req_valid=1, addr=0x10000, tag=2, write=0; grant_count=1. Response tag=2 → resp_valid=8'b0000_0100, cnt[2] returns to 0.
2. Ports 0, 3 and 5 held valid, instant ready, responses returned immediately → grants in order 0,3,5,0,3,5, one grant per 2 cycles.
3. Port 1 valid, no responses returned → exactly 4 grants to port 1, then req_ready[1] stays 0. One response tag=1 → a 5th grant follows.
4. cache_req_ready held 0 for 5 cycles with a write of data 0xA5… → cache_req_* stable across all 5 cycles; transitions to ARB on the cycle ready=1.
5. Two requests outstanding on port 4, snoop_req asserted → no new grants, snoop_ack=0. Return both responses → snoop_ack=1 in the cycle after the second response. Drop snoop_req → arbitration resumes.
6. Response tag=6 with cnt[6]==0 → protocol_error=1 and stays 1. Same-cycle grant and response on port 0 with cnt[0]=1 → cnt[0] stays 1.

Source files
------------

// File: rtl/l3_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : l3_port_arbiter
// Purpose  : Round-robin L2->L3 request arbiter with source tagging, response
//            routing, per-port outstanding limits and snoop quiescing.
// Revision : 1.0 - initial release
// ============================================================================
module l3_port_arbiter #(
    parameter int NUM_PORTS       = 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic                            cache_req_valid,
    input  logic                            cache_req_ready,
    output logic [ADDR_WIDTH-1:0]           cache_req_addr,
    output logic                            cache_req_write,
    output logic [DATA_WIDTH-1:0]           cache_req_wdata,
    output logic [TAG_WIDTH-1:0]            cache_req_tag,
    input  logic                            cache_resp_valid,
    input  logic [TAG_WIDTH-1:0]            cache_resp_tag,
    input  logic [DATA_WIDTH-1:0]           cache_resp_data,
    output logic [NUM_PORTS-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_data,
    input  logic                            snoop_req,
    output logic                            snoop_ack,
    output logic                            protocol_error,
    output logic [31:0]                     grant_count
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]                          state_q, state_d;
    logic [TAG_WIDTH-1:0]                rr_q, rr_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic                                cache_req_valid_q, cache_req_valid_d;
    logic [ADDR_WIDTH-1:0]               cache_req_addr_q, cache_req_addr_d;
    logic                                cache_req_write_q, cache_req_write_d;
    logic [DATA_WIDTH-1:0]               cache_req_wdata_q, cache_req_wdata_d;
    logic [TAG_WIDTH-1:0]                cache_req_tag_q, cache_req_tag_d;
    logic                                protocol_error_q, protocol_error_d;
    logic [31:0]                         grant_count_q, grant_count_d;

    logic [NUM_PORTS-1:0]  eligible;
    logic [NUM_PORTS-1:0]  resp_hit;
    logic [NUM_PORTS-1:0]  resp_ok;
    logic                  grant_found;
    logic                  grant;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_write;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  cnt_busy;
    logic                  resp_err;

    function automatic logic [TAG_WIDTH-1:0] wrap_add(input logic [TAG_WIDTH-1:0] base,
                                                      input int                   off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return TAG_WIDTH'(sum);
    endfunction

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign eligible[p]   = req_valid[p] && (cnt_q[p] < CNT_W'(MAX_OUTSTANDING)) && !snoop_req;
            assign req_ready[p]  = grant && (grant_idx == TAG_WIDTH'(p));
            assign resp_hit[p]   = cache_resp_valid && (cache_resp_tag == TAG_WIDTH'(p));
            assign resp_ok[p]    = resp_hit[p] && (cnt_q[p] != '0);
        end
    endgenerate

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && eligible[wrap_add(rr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_add(rr_q, i);
            end
        end
    end

    assign grant = (state_q == ST_ARB) && grant_found;

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == TAG_WIDTH'(p)) begin
                sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_write = req_write[p];
                sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A grant and a valid response on the same port cancel each other out.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_busy = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_ready[p] && !resp_ok[p]) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end else if (!req_ready[p] && resp_ok[p]) begin
                cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end
            if (cnt_q[p] != '0) begin
                cnt_busy = 1'b1;
            end
        end
    end

    assign resp_err = cache_resp_valid && !(|resp_ok);

    always_comb begin
        state_d           = state_q;
        rr_d              = rr_q;
        cache_req_valid_d = cache_req_valid_q;
        cache_req_addr_d  = cache_req_addr_q;
        cache_req_write_d = cache_req_write_q;
        cache_req_wdata_d = cache_req_wdata_q;
        cache_req_tag_d   = cache_req_tag_q;
        grant_count_d     = grant_count_q;
        protocol_error_d  = protocol_error_q | resp_err;
        case (state_q)
            ST_ARB: begin
                if (grant_found) begin
                    cache_req_valid_d = 1'b1;
                    cache_req_addr_d  = sel_addr;
                    cache_req_write_d = sel_write;
                    cache_req_wdata_d = sel_wdata;
                    cache_req_tag_d   = grant_idx;
                    grant_count_d     = grant_count_q + 32'd1;
                    rr_d              = wrap_add(grant_idx, 1);
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cache_req_ready) begin
                    cache_req_valid_d = 1'b0;
                    state_d           = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_ARB;
            rr_q              <= '0;
            cnt_q             <= '0;
            cache_req_valid_q <= 1'b0;
            cache_req_addr_q  <= '0;
            cache_req_write_q <= 1'b0;
            cache_req_wdata_q <= '0;
            cache_req_tag_q   <= '0;
            protocol_error_q  <= 1'b0;
            grant_count_q     <= '0;
        end else begin
            state_q           <= state_d;
            rr_q              <= rr_d;
            cnt_q             <= cnt_d;
            cache_req_valid_q <= cache_req_valid_d;
            cache_req_addr_q  <= cache_req_addr_d;
            cache_req_write_q <= cache_req_write_d;
            cache_req_wdata_q <= cache_req_wdata_d;
            cache_req_tag_q   <= cache_req_tag_d;
            protocol_error_q  <= protocol_error_d;
            grant_count_q     <= grant_count_d;
        end
    end

    assign cache_req_valid = cache_req_valid_q;
    assign cache_req_addr  = cache_req_addr_q;
    assign cache_req_write = cache_req_write_q;
    assign cache_req_wdata = cache_req_wdata_q;
    assign cache_req_tag   = cache_req_tag_q;
    assign resp_valid      = resp_hit;
    assign resp_data       = cache_resp_data;
    assign snoop_ack       = snoop_req && (state_q == ST_ARB) && !cnt_busy;
    assign protocol_error  = protocol_error_q;
    assign grant_count     = grant_count_q;

endmodule
`default_nettype wire

// File: tb/tb_l3_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_l3_port_arbiter
// Purpose  : Scoreboard-based self-checking bench for l3_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l3_port_arbiter;

    localparam int NP = 8;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_ready;
    logic [NP*AW-1:0]  req_addr;
    logic [NP-1:0]     req_write;
    logic [NP*DW-1:0]  req_wdata;
    logic              cache_req_valid;
    logic              cache_req_ready;
    logic [AW-1:0]     cache_req_addr;
    logic              cache_req_write;
    logic [DW-1:0]     cache_req_wdata;
    logic [TW-1:0]     cache_req_tag;
    logic              cache_resp_valid;
    logic [TW-1:0]     cache_resp_tag;
    logic [DW-1:0]     cache_resp_data;
    logic [NP-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic              snoop_req;
    logic              snoop_ack;
    logic              protocol_error;
    logic [31:0]       grant_count;

    always #5 clk = ~clk;

    l3_port_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_write        (req_write),
        .req_wdata        (req_wdata),
        .cache_req_valid  (cache_req_valid),
        .cache_req_ready  (cache_req_ready),
        .cache_req_addr   (cache_req_addr),
        .cache_req_write  (cache_req_write),
        .cache_req_wdata  (cache_req_wdata),
        .cache_req_tag    (cache_req_tag),
        .cache_resp_valid (cache_resp_valid),
        .cache_resp_tag   (cache_resp_tag),
        .cache_resp_data  (cache_resp_data),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .snoop_req        (snoop_req),
        .snoop_ack        (snoop_ack),
        .protocol_error   (protocol_error),
        .grant_count      (grant_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            hs_cnt  = 0;
    int            gnt_cnt = 0;
    logic [TW-1:0] last_tag = '0;

    task automatic check_eq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req_valid[p]           = 1'b1;
        req_addr[p*AW +: AW]   = a;
        req_write[p]           = w;
        req_wdata[p*DW +: DW]  = d;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input int p);
        exp_t e;
        e.addr  = a;
        e.wr    = w;
        e.wdata = d;
        e.tag   = TW'(p);
        exp_q.push_back(e);
    endtask

    // Observe the upcoming clock edge (grant / downstream handshake), then move to the next negedge.
    task automatic nxt();
        exp_t e;
        #1;
        if (|req_ready) gnt_cnt++;
        if (rst_n && cache_req_valid && cache_req_ready) begin
            hs_cnt++;
            last_tag = cache_req_tag;
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_issue", DW'(1), DW'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_tag", DW'(cache_req_tag), DW'(e.tag));
                check_eq("sb_addr", DW'(cache_req_addr), DW'(e.addr));
                check_eq("sb_write", DW'(cache_req_write), DW'(e.wr));
                if (e.wr) check_eq("sb_wdata", cache_req_wdata, e.wdata);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        req_valid        = '0;
        req_addr         = '0;
        req_write        = '0;
        req_wdata        = '0;
        cache_req_ready  = 1'b0;
        cache_resp_valid = 1'b0;
        cache_resp_tag   = '0;
        cache_resp_data  = '0;
        snoop_req        = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            hs0;
        int            g0;
        int            cyc;
        int            h;
        logic          pend;
        logic [TW-1:0] ptag;
        logic [DW-1:0] pat;

        // Single read through the whole path
        do_reset();
        check_eq("rst_cache_req_valid", DW'(cache_req_valid), DW'(0));
        check_eq("rst_cache_req_addr", DW'(cache_req_addr), DW'(0));
        check_eq("rst_cache_req_tag", DW'(cache_req_tag), DW'(0));
        check_eq("rst_grant_count", DW'(grant_count), DW'(0));
        check_eq("rst_protocol_error", DW'(protocol_error), DW'(0));
        check_eq("rst_req_ready", DW'(req_ready), DW'(0));
        set_port(2, 64'h10000, 1'b0, '0);
        cache_req_ready = 1'b1;
        push_exp(64'h10000, 1'b0, '0, 2);
        #1;
        check_eq("t1_req_ready", DW'(req_ready), DW'(8'b0000_0100));
        nxt();
        req_valid = '0;
        check_eq("t1_issue_valid", DW'(cache_req_valid), DW'(1));
        check_eq("t1_issue_tag", DW'(cache_req_tag), DW'(2));
        check_eq("t1_issue_addr", DW'(cache_req_addr), DW'(64'h10000));
        check_eq("t1_issue_write", DW'(cache_req_write), DW'(0));
        check_eq("t1_grant_count", DW'(grant_count), DW'(1));
        nxt();
        check_eq("t1_valid_drop", DW'(cache_req_valid), DW'(0));
        pat = {16{32'hDEADBEEF}};
        cache_resp_valid = 1'b1;
        cache_resp_tag   = 3'd2;
        cache_resp_data  = pat;
        #1;
        check_eq("t1_resp_valid", DW'(resp_valid), DW'(8'b0000_0100));
        check_eq("t1_resp_data", resp_data, pat);
        nxt();
        cache_resp_valid = 1'b0;
        snoop_req = 1'b1;
        #1;
        check_eq("t1_cnt_zero_ack", DW'(snoop_ack), DW'(1));
        check_eq("t1_no_proto_err", DW'(protocol_error), DW'(0));
        snoop_req = 1'b0;

        // Three contending ports, immediate ready and responses
        do_reset();
        set_port(0, 64'h1000, 1'b0, '0);
        set_port(3, 64'h4000, 1'b0, '0);
        set_port(5, 64'h6000, 1'b0, '0);
        cache_req_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_exp(64'h1000, 1'b0, '0, 0);
            push_exp(64'h4000, 1'b0, '0, 3);
            push_exp(64'h6000, 1'b0, '0, 5);
        end
        hs0  = hs_cnt;
        cyc  = 0;
        pend = 1'b0;
        ptag = '0;
        while ((hs_cnt - hs0) < 6 && cyc < 40) begin
            cache_resp_valid = pend;
            cache_resp_tag   = ptag;
            pend = 1'b0;
            h = hs_cnt;
            nxt();
            cyc++;
            if (hs_cnt != h) begin
                pend = 1'b1;
                ptag = last_tag;
            end
        end
        req_valid = '0;
        cache_resp_valid = pend;
        cache_resp_tag   = ptag;
        nxt();
        cache_resp_valid = 1'b0;
        check_eq("t2_handshakes", DW'(hs_cnt - hs0), DW'(6));
        check_eq("t2_cycles", DW'(cyc), DW'(12));
        check_eq("t2_grant_count", DW'(grant_count), DW'(6));
        check_eq("t2_sb_drained", DW'(exp_q.size()), DW'(0));
        snoop_req = 1'b1;
        #1;
        check_eq("t2_all_returned_ack", DW'(snoop_ack), DW'(1));
        snoop_req = 1'b0;

        // Outstanding limit on a single port
        do_reset();
        set_port(1, 64'h3000, 1'b0, '0);
        cache_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_exp(64'h3000, 1'b0, '0, 1);
        hs0 = hs_cnt;
        g0  = gnt_cnt;
        repeat (20) nxt();
        check_eq("t3_grants_at_limit", DW'(gnt_cnt - g0), DW'(4));
        check_eq("t3_ready_blocked", DW'(req_ready), DW'(0));
        check_eq("t3_grant_count", DW'(grant_count), DW'(4));
        cache_resp_valid = 1'b1;
        cache_resp_tag   = 3'd1;
        nxt();
        cache_resp_valid = 1'b0;
        cyc = 0;
        while ((hs_cnt - hs0) < 5 && cyc < 10) begin
            nxt();
            cyc++;
        end
        req_valid = '0;
        check_eq("t3_fifth_issue", DW'(hs_cnt - hs0), DW'(5));
        check_eq("t3_fifth_grant", DW'(gnt_cnt - g0), DW'(5));
        check_eq("t3_sb_drained", DW'(exp_q.size()), DW'(0));

        // Downstream backpressure holds the issued write stable
        do_reset();
        pat = {16{32'hA5A5A5A5}};
        set_port(6, 64'h2000_0040, 1'b1, pat);
        cache_req_ready = 1'b0;
        push_exp(64'h2000_0040, 1'b1, pat, 6);
        nxt();
        req_valid = '0;
        req_wdata = '0;
        for (int k = 0; k < 5; k++) begin
            check_eq("t4_hold_valid", DW'(cache_req_valid), DW'(1));
            check_eq("t4_hold_addr", DW'(cache_req_addr), DW'(64'h2000_0040));
            check_eq("t4_hold_write", DW'(cache_req_write), DW'(1));
            check_eq("t4_hold_wdata", cache_req_wdata, pat);
            check_eq("t4_hold_tag", DW'(cache_req_tag), DW'(6));
            nxt();
        end
        cache_req_ready = 1'b1;
        hs0 = hs_cnt;
        nxt();
        check_eq("t4_handshake", DW'(hs_cnt - hs0), DW'(1));
        check_eq("t4_back_to_arb", DW'(cache_req_valid), DW'(0));

        // Snoop quiesce with two requests in flight on port 4
        do_reset();
        cache_req_ready = 1'b1;
        set_port(4, 64'h4400, 1'b0, '0);
        push_exp(64'h4400, 1'b0, '0, 4);
        push_exp(64'h4400, 1'b0, '0, 4);
        hs0 = hs_cnt;
        cyc = 0;
        while ((hs_cnt - hs0) < 2 && cyc < 10) begin
            nxt();
            cyc++;
        end
        req_valid = '0;
        check_eq("t5_two_issued", DW'(hs_cnt - hs0), DW'(2));
        snoop_req = 1'b1;
        set_port(4, 64'h4400, 1'b0, '0);
        set_port(0, 64'h5000, 1'b0, '0);
        g0 = gnt_cnt;
        #1;
        check_eq("t5_snoop_no_ready", DW'(req_ready), DW'(0));
        check_eq("t5_ack_busy", DW'(snoop_ack), DW'(0));
        repeat (3) nxt();
        check_eq("t5_no_grants", DW'(gnt_cnt - g0), DW'(0));
        cache_resp_valid = 1'b1;
        cache_resp_tag   = 3'd4;
        #1;
        check_eq("t5_ack_two_out", DW'(snoop_ack), DW'(0));
        nxt();
        check_eq("t5_ack_one_out", DW'(snoop_ack), DW'(0));
        nxt();
        cache_resp_valid = 1'b0;
        #1;
        check_eq("t5_ack_quiesced", DW'(snoop_ack), DW'(1));
        check_eq("t5_still_no_grants", DW'(gnt_cnt - g0), DW'(0));
        snoop_req = 1'b0;
        push_exp(64'h5000, 1'b0, '0, 0);
        #1;
        check_eq("t5_resume_rr", DW'(req_ready), DW'(8'b0000_0001));
        hs0 = hs_cnt;
        cyc = 0;
        while ((hs_cnt - hs0) < 1 && cyc < 5) begin
            nxt();
            cyc++;
        end
        req_valid = '0;
        check_eq("t5_resume_issue", DW'(hs_cnt - hs0), DW'(1));
        check_eq("t5_sb_drained", DW'(exp_q.size()), DW'(0));

        // Protocol error and same-cycle grant/response
        do_reset();
        check_eq("t6_err_clear", DW'(protocol_error), DW'(0));
        cache_resp_valid = 1'b1;
        cache_resp_tag   = 3'd6;
        #1;
        check_eq("t6_resp_valid_err", DW'(resp_valid), DW'(8'b0100_0000));
        nxt();
        cache_resp_valid = 1'b0;
        check_eq("t6_err_set", DW'(protocol_error), DW'(1));
        repeat (3) nxt();
        check_eq("t6_err_sticky", DW'(protocol_error), DW'(1));
        cache_req_ready = 1'b1;
        set_port(0, 64'h6000, 1'b0, '0);
        push_exp(64'h6000, 1'b0, '0, 0);
        nxt();
        req_valid = '0;
        nxt();
        set_port(0, 64'h6040, 1'b0, '0);
        push_exp(64'h6040, 1'b0, '0, 0);
        cache_resp_valid = 1'b1;
        cache_resp_tag   = 3'd0;
        #1;
        check_eq("t6_same_cycle_ready", DW'(req_ready), DW'(8'b0000_0001));
        nxt();
        req_valid = '0;
        cache_resp_valid = 1'b0;
        nxt();
        snoop_req = 1'b1;
        #1;
        check_eq("t6_cnt_still_one", DW'(snoop_ack), DW'(0));
        cache_resp_valid = 1'b1;
        cache_resp_tag   = 3'd0;
        nxt();
        cache_resp_valid = 1'b0;
        #1;
        check_eq("t6_cnt_now_zero", DW'(snoop_ack), DW'(1));
        check_eq("t6_err_kept", DW'(protocol_error), DW'(1));
        check_eq("t6_sb_drained", DW'(exp_q.size()), DW'(0));
        snoop_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
